apb_to_tl: RTL
==============

Name: apb_to_tl

Overview:
- APB3 completer to TileLink-UL bridge, single outstanding transaction; the reverse direction of the existing TL-to-APB converter.
- Lets APB-only initiators (debug/boot sequencer, DMA config engine) reach TL-attached slaves such as the PLIC and CLINT.
- Each APB access phase becomes one TL Get or PutFullData on channel A. The matching channel D beat completes the APB transfer with pready/prdata/pslverr.

Parameters:
- ADDR_WIDTH, 32, APB and TL address width.
- DATA_WIDTH, 32, APB and TL data width (32 or 64).
- SOURCE_ID, 0, constant tl_a_source_o value; 4 bits wide.
- TIMEOUT_CYCLES, 1024, D-wait limit, used only with the optional feature.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- psel_i  in  1  APB select
- penable_i  in  1  APB enable
- pwrite_i  in  1  APB write
- paddr_i  in  ADDR_WIDTH  APB address
- pwdata_i  in  DATA_WIDTH  APB write data
- prdata_o  out  DATA_WIDTH  APB read data
- pready_o  out  1  APB ready
- pslverr_o  out  1  APB error
- tl_a_valid_o  out  1  A valid
- tl_a_ready_i  in  1  A ready
- tl_a_opcode_o  out  3  4=Get, 0=PutFullData
- tl_a_param_o  out  3  always 0
- tl_a_size_o  out  3  log2(DATA_WIDTH/8)
- tl_a_source_o  out  4  SOURCE_ID
- tl_a_address_o  out  ADDR_WIDTH  address
- tl_a_mask_o  out  DATA_WIDTH/8  all ones
- tl_a_data_o  out  DATA_WIDTH  write data, 0 for Get
- tl_d_valid_i  in  1  D valid
- tl_d_ready_o  out  1  D ready
- tl_d_opcode_i  in  3  0=AccessAck, 1=AccessAckData
- tl_d_denied_i  in  1  denied
- tl_d_corrupt_i  in  1  corrupt
- tl_d_data_i  in  DATA_WIDTH  read data

Behaviour:
- Interface: one clock clk_i; reset rst_i is synchronous and active-high.
- Reset values: tl_a_valid_o=0, tl_d_ready_o=0, pready_o=0, pslverr_o=0, prdata_o=0. FSM goes to IDLE.
- Reset mid-operation: aborts any transaction with no APB response. The TL fabric is reset together with this block, so no late D beat arrives.
- FSM states: IDLE, A_REQ, D_WAIT, RESP (plus DRAIN with the optional feature).
- IDLE:
  - On psel_i & penable_i, latch pwrite/paddr/pwdata.
  - If paddr_i low log2(DATA_WIDTH/8) bits are nonzero (misaligned), go to RESP with err=1 and issue no TL request.
  - Otherwise go to A_REQ.
- A_REQ:
  - tl_a_valid_o=1; all A fields come from latched registers and stay stable until tl_a_ready_i.
  - On tl_a_valid_o & tl_a_ready_i, go to D_WAIT.
- D_WAIT:
  - tl_d_ready_o=1.
  - On tl_d_valid_i, latch the response and go to RESP.
- Response error flag err=1 if any of:
  - tl_d_denied_i;
  - opcode mismatch (read expects 1, write expects 0);
  - tl_d_corrupt_i on a read.
- prdata latch: tl_d_data_i on a good read; 0 on writes and on errors.
- RESP:
  - pready_o=1 for exactly one cycle, with pslverr_o=err and prdata_o valid. Then IDLE.
  - pready_o, pslverr_o and prdata_o are 0 in every state other than RESP.
- Minimum latency, with a_ready and d_valid immediate:
  - access phase seen at cycle T;
  - A handshake at T+1;
  - D accepted at T+2;
  - pready_o at T+3.
- Extra cycles of a_ready low or d_valid late add cycle-for-cycle.
- Only one transaction is outstanding. APB stays in the access phase (pready low) throughout.
- psel_i deasserted mid-transaction (protocol violation): the TL transaction still completes and the RESP pulse is still emitted.
- A D beat arriving outside D_WAIT/DRAIN is not accepted (tl_d_ready_o=0).

Optional Feature:
- Macro: APB_TO_TL_TIMEOUT_EN.
- Defined:
  - A counter is cleared on D_WAIT entry and increments each D_WAIT cycle.
  - Reaching TIMEOUT_CYCLES-1 without tl_d_valid_i goes to RESP with err=1 and prdata 0, then to DRAIN instead of IDLE.
  - DRAIN holds tl_d_ready_o=1, discards the next D beat, then goes to IDLE.
  - New APB transfers are not started in DRAIN (pready_o stays low).
- Undefined: no counter, no DRAIN; D_WAIT waits indefinitely.

Test Plan:
- APB write 0x0C00_0004 data 0x0000_0005, a_ready=1, AccessAck after 0 cycles -> A opcode 0, mask 0xF, size 2, data 0x5; pready_o one cycle at T+3; pslverr_o=0.
- APB read 0x0C20_0004, a_ready low for 3 cycles, AccessAckData 0x0000_0011 after 5 cycles -> A fields stable while stalled; prdata_o=0x11, pslverr_o=0, pready_o single pulse.
- Read with tl_d_denied_i=1 -> pslverr_o=1, prdata_o=0. Write answered with opcode 1 -> pslverr_o=1.
- Misaligned read paddr 0x0C00_0002 -> no tl_a_valid_o; pready_o at T+1 with pslverr_o=1.
- rst_i asserted while in A_REQ -> next cycle tl_a_valid_o=0, no pready_o; subsequent read completes normally.
- With APB_TO_TL_TIMEOUT_EN and TIMEOUT_CYCLES=16, no D for 16 cycles -> pslverr_o=1. Late D beat is drained. A following APB access issues no A request until after the drain.

Source files
------------

// File: rtl/apb_to_tl_if.sv
// Bus bundle for apb_to_tl: APB3 completer side plus TileLink-UL channels A and D.
// The slave modport is the bridge's view; the master modport is the view of
// everything around it (APB initiator and TL fabric).
interface apb_to_tl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      psel_i;
    logic                      penable_i;
    logic                      pwrite_i;
    logic [ADDR_WIDTH-1:0]     paddr_i;
    logic [DATA_WIDTH-1:0]     pwdata_i;
    logic [DATA_WIDTH-1:0]     prdata_o;
    logic                      pready_o;
    logic                      pslverr_o;

    logic                      tl_a_valid_o;
    logic                      tl_a_ready_i;
    logic [2:0]                tl_a_opcode_o;
    logic [2:0]                tl_a_param_o;
    logic [2:0]                tl_a_size_o;
    logic [3:0]                tl_a_source_o;
    logic [ADDR_WIDTH-1:0]     tl_a_address_o;
    logic [DATA_WIDTH/8-1:0]   tl_a_mask_o;
    logic [DATA_WIDTH-1:0]     tl_a_data_o;

    logic                      tl_d_valid_i;
    logic                      tl_d_ready_o;
    logic [2:0]                tl_d_opcode_i;
    logic                      tl_d_denied_i;
    logic                      tl_d_corrupt_i;
    logic [DATA_WIDTH-1:0]     tl_d_data_i;

    modport slave (
        input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
        output prdata_o, pready_o, pslverr_o,
        output tl_a_valid_o, tl_a_opcode_o, tl_a_param_o, tl_a_size_o,
               tl_a_source_o, tl_a_address_o, tl_a_mask_o, tl_a_data_o,
        input  tl_a_ready_i,
        input  tl_d_valid_i, tl_d_opcode_i, tl_d_denied_i, tl_d_corrupt_i, tl_d_data_i,
        output tl_d_ready_o
    );

    modport master (
        output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
        input  prdata_o, pready_o, pslverr_o,
        input  tl_a_valid_o, tl_a_opcode_o, tl_a_param_o, tl_a_size_o,
               tl_a_source_o, tl_a_address_o, tl_a_mask_o, tl_a_data_o,
        output tl_a_ready_i,
        output tl_d_valid_i, tl_d_opcode_i, tl_d_denied_i, tl_d_corrupt_i, tl_d_data_i,
        input  tl_d_ready_o
    );
endinterface

// File: rtl/apb_to_tl.sv
// APB3 completer to TileLink-UL bridge, one transaction outstanding.
// Each APB access becomes one Get/PutFullData on channel A; the channel D beat
// completes the APB transfer. Misaligned addresses are rejected locally.
// Optional macro APB_TO_TL_TIMEOUT_EN: bounds the D wait to TIMEOUT_CYCLES and
// then drains the late D beat before accepting new APB transfers.
module apb_to_tl #(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          DATA_WIDTH     = 32,
    parameter logic [3:0]  SOURCE_ID      = 4'd0,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic           clk_i,
    input  logic           rst_i,
    apb_to_tl_if.slave     bus
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int SIZE   = $clog2(STRB_W);

    localparam logic [2:0] OP_GET      = 3'd4;
    localparam logic [2:0] OP_PUT_FULL = 3'd0;
    localparam logic [2:0] OP_ACK      = 3'd0;
    localparam logic [2:0] OP_ACK_DATA = 3'd1;

    // Elaboration guard: a timeout shorter than two cycles cannot be counted.
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("apb_to_tl: TIMEOUT_CYCLES must be at least 2");
    end

`ifdef APB_TO_TL_TIMEOUT_EN
    typedef enum logic [2:0] {IDLE, A_REQ, D_WAIT, RESP, DRAIN} state_e;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q, to_d;
`else
    typedef enum logic [1:0] {IDLE, A_REQ, D_WAIT, RESP} state_e;
`endif

    state_e                state_q, state_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  a_valid;
    logic                  d_ready;
    logic                  resp;
    logic                  d_err;

    // Response error from the D beat as seen in D_WAIT.
    always_comb begin
        d_err = bus.tl_d_denied_i
              | (bus.tl_d_opcode_i != (write_q ? OP_ACK : OP_ACK_DATA))
              | (~write_q & bus.tl_d_corrupt_i);
    end

    // Control state: reset returns to IDLE and aborts anything in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
`ifdef APB_TO_TL_TIMEOUT_EN
            cnt_q   <= '0;
            to_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
`ifdef APB_TO_TL_TIMEOUT_EN
            cnt_q   <= cnt_d;
            to_q    <= to_d;
`endif
        end
    end

    // Latched request and response data; only observed once qualified by state.
    always_ff @(posedge clk_i) begin
        write_q <= write_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        rdata_q <= rdata_d;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        a_valid = 1'b0;
        d_ready = 1'b0;
        resp    = 1'b0;
`ifdef APB_TO_TL_TIMEOUT_EN
        cnt_d   = cnt_q;
        to_d    = to_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.psel_i && bus.penable_i) begin
                    write_d = bus.pwrite_i;
                    addr_d  = bus.paddr_i;
                    wdata_d = bus.pwdata_i;
                    rdata_d = '0;
                    if (|bus.paddr_i[SIZE-1:0]) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = A_REQ;
                    end
                end
            end
            A_REQ: begin
                a_valid = 1'b1;
                if (bus.tl_a_ready_i) begin
                    state_d = D_WAIT;
`ifdef APB_TO_TL_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            D_WAIT: begin
                d_ready = 1'b1;
                if (bus.tl_d_valid_i) begin
                    err_d   = d_err;
                    rdata_d = (d_err || write_q) ? '0 : bus.tl_d_data_i;
                    state_d = RESP;
`ifdef APB_TO_TL_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    to_d    = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            RESP: begin
                resp = 1'b1;
`ifdef APB_TO_TL_TIMEOUT_EN
                to_d    = 1'b0;
                state_d = to_q ? DRAIN : IDLE;
`else
                state_d = IDLE;
`endif
            end
`ifdef APB_TO_TL_TIMEOUT_EN
            DRAIN: begin
                // The late D beat of the timed-out request is swallowed here.
                d_ready = 1'b1;
                if (bus.tl_d_valid_i) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.tl_a_valid_o   = a_valid;
    assign bus.tl_a_opcode_o  = write_q ? OP_PUT_FULL : OP_GET;
    assign bus.tl_a_param_o   = 3'd0;
    assign bus.tl_a_size_o    = 3'(SIZE);
    assign bus.tl_a_source_o  = SOURCE_ID;
    assign bus.tl_a_address_o = addr_q;
    assign bus.tl_a_mask_o    = {STRB_W{1'b1}};
    assign bus.tl_a_data_o    = write_q ? wdata_q : '0;
    assign bus.tl_d_ready_o   = d_ready;
    assign bus.pready_o       = resp;
    assign bus.pslverr_o      = resp & err_q;
    assign bus.prdata_o       = resp ? rdata_q : '0;

endmodule
